// File: rtl/cpu_pkg.sv
// Shared types and helpers for the hazard scoreboard: the per-stage entry record and
// the width of a stage-select index that can also encode "no stage".
package cpu_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } sb_entry_t;

  // Index width able to hold 0..nstage, where nstage itself means "no match".
  function automatic int unsigned fwd_sel(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: decoded operands in, stall and
// forwarded operands out, plus the per-stage result bus from the datapath.
interface hazard_scoreboard_if #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned DW     = 32
);
  logic                   d_valid;
  logic [4:0]             d_rs;
  logic [4:0]             d_rt;
  logic                   d_rs_used;
  logic                   d_rt_used;
  logic [4:0]             d_rd;
  logic                   d_wen;
  logic                   d_load;
  logic [DW-1:0]          d_vs;
  logic [DW-1:0]          d_vt;
  logic                   freeze;
  logic                   flush;
  logic [NSTAGE*DW-1:0]   stage_data;
  logic                   stall;
  logic [DW-1:0]          vs_fwd;
  logic [DW-1:0]          vt_fwd;
  logic [NSTAGE-1:0]      stage_valid;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_wen, d_load, d_vs, d_vt,
    output freeze, flush, stage_data,
    input  stall, vs_fwd, vt_fwd, stage_valid
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_wen, d_load, d_vs, d_vt,
    input  freeze, flush, stage_data,
    output stall, vs_fwd, vt_fwd, stage_valid
  );
endinterface

// File: rtl/hazard_match.sv
// Finds the youngest in-flight writer of one source register and reports whether
// its result is already available for forwarding.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned READY_ALU  = 1,
  parameter int unsigned READY_LOAD = 2,
  localparam int unsigned IdxW      = fwd_sel(NSTAGE)
) (
  input  sb_entry_t [NSTAGE-1:0] entries,
  input  logic [4:0]             src,
  input  logic                   used,
  output logic                   hit,
  output logic                   ready,
  output logic [IdxW-1:0]        idx
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    idx   = IdxW'(NSTAGE);
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      if (used && (src != REG_ZERO) && entries[i].valid && (entries[i].rd == src)) begin
        hit   = 1'b1;
        idx   = IdxW'(i);
        ready = (i >= (entries[i].load ? int'(READY_LOAD) : int'(READY_ALU)));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard for the in-order pipeline: decode stall, load-use
// interlock and operand forwarding. HAZARD_STATS_EN adds stall/load-use counters.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned READY_ALU  = 1,
  parameter int unsigned READY_LOAD = 2,
  parameter int unsigned DW         = 32
) (
  input  logic                clk,
  input  logic                resetn,
  hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         loaduse_cnt
`endif
);

  localparam int unsigned IdxW = fwd_sel(NSTAGE);

  sb_entry_t [NSTAGE-1:0] entries_q, entries_d;
  sb_entry_t              new_entry;

  logic            hit_s, ready_s, hit_t, ready_t;
  logic [IdxW-1:0] idx_s, idx_t;

  hazard_match #(
    .NSTAGE    (NSTAGE),
    .READY_ALU (READY_ALU),
    .READY_LOAD(READY_LOAD)
  ) u_match_s (
    .entries(entries_q),
    .src    (bus.d_rs),
    .used   (bus.d_rs_used),
    .hit    (hit_s),
    .ready  (ready_s),
    .idx    (idx_s)
  );

  hazard_match #(
    .NSTAGE    (NSTAGE),
    .READY_ALU (READY_ALU),
    .READY_LOAD(READY_LOAD)
  ) u_match_t (
    .entries(entries_q),
    .src    (bus.d_rt),
    .used   (bus.d_rt_used),
    .hit    (hit_t),
    .ready  (ready_t),
    .idx    (idx_t)
  );

  always_comb begin
    bus.stall = bus.d_valid & ((hit_s & ~ready_s) | (hit_t & ~ready_t));
  end

  always_comb begin
    bus.vs_fwd = bus.d_vs;
    bus.vt_fwd = bus.d_vt;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      if (hit_s && ready_s && (idx_s == IdxW'(i))) bus.vs_fwd = bus.stage_data[i*DW +: DW];
      if (hit_t && ready_t && (idx_t == IdxW'(i))) bus.vt_fwd = bus.stage_data[i*DW +: DW];
    end
  end

  // A stalled or flushed decode slot enters E as a bubble.
  always_comb begin
    new_entry.valid = bus.d_valid & bus.d_wen & ~bus.stall & ~bus.flush;
    new_entry.rd    = bus.d_rd;
    new_entry.load  = bus.d_load;
  end

  always_comb begin
    entries_d = entries_q;
    if (!bus.freeze) begin
      entries_d[0] = new_entry;
      for (int i = 1; i < int'(NSTAGE); i++) begin
        entries_d[i] = entries_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NSTAGE); i++) begin
      bus.stage_valid[i] = entries_q[i].valid;
    end
  end

`ifdef HAZARD_STATS_EN
  logic        load_s, load_t, loaduse_stall;
  logic [31:0] stall_cnt_q, stall_cnt_d, loaduse_cnt_q, loaduse_cnt_d;

  always_comb begin
    load_s = 1'b0;
    load_t = 1'b0;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      if (idx_s == IdxW'(i)) load_s = entries_q[i].load;
      if (idx_t == IdxW'(i)) load_t = entries_q[i].load;
    end
    loaduse_stall = bus.d_valid &
                    ((hit_s & ~ready_s & load_s) | (hit_t & ~ready_t & load_t));
  end

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    loaduse_cnt_d = loaduse_cnt_q;
    if (bus.stall && !bus.freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (loaduse_stall && !bus.freeze && (loaduse_cnt_q != '1)) begin
      loaduse_cnt_d = loaduse_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q   <= '0;
      loaduse_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      loaduse_cnt_q <= loaduse_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign loaduse_cnt = loaduse_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus random
// decode traffic checked against a queue-based model of the in-flight writers.
module tb_hazard_scoreboard;

  localparam int unsigned NSTAGE     = 3;
  localparam int unsigned DW         = 32;
  localparam int unsigned READY_ALU  = 1;
  localparam int unsigned READY_LOAD = 2;

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       load;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;

  hazard_scoreboard_if #(.NSTAGE(NSTAGE), .DW(DW)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, loaduse_cnt;
  int unsigned exp_stall_cnt = 0, exp_lu_cnt = 0;
`endif

  hazard_scoreboard #(
    .NSTAGE    (NSTAGE),
    .READY_ALU (READY_ALU),
    .READY_LOAD(READY_LOAD),
    .DW        (DW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .loaduse_cnt(loaduse_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t pipe[$];                 // index 0 = youngest (stage E)
  logic [DW-1:0] cur_vs, cur_vt;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_clear();
    ent_t z;
    z.valid = 0; z.rd = 0; z.load = 0;
    pipe.delete();
    for (int i = 0; i < int'(NSTAGE); i++) pipe.push_back(z);
  endfunction

  function automatic void model_find(input bit [4:0] src, input bit used,
                                     output bit hit, output bit rdy, output int idx);
    hit = 0; rdy = 0; idx = -1;
    if (!used || src == 0) return;
    foreach (pipe[i]) begin
      if (pipe[i].valid && pipe[i].rd == src) begin
        hit = 1;
        idx = i;
        rdy = (i >= int'(pipe[i].load ? READY_LOAD : READY_ALU));
        return;
      end
    end
  endfunction

  function automatic logic [DW-1:0] slice(input int i);
    return bus.stage_data[i*DW +: DW];
  endfunction

  task automatic instr(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit rsu,
                       input bit rtu, input bit [4:0] rd, input bit wen, input bit ld);
    cur_vs = $urandom;
    cur_vt = $urandom;
    bus.d_valid = v;   bus.d_rs = rs;     bus.d_rt = rt;
    bus.d_rs_used = rsu; bus.d_rt_used = rtu;
    bus.d_rd = rd;     bus.d_wen = wen;   bus.d_load = ld;
    bus.d_vs = cur_vs; bus.d_vt = cur_vt;
  endtask

  // Check combinational outputs against the model, clock once, advance the model.
  task automatic cycle();
    bit hs, rs_, ht, rt_, st, lu;
    int is, it;
    logic [NSTAGE-1:0] sv;
    ent_t e;
    #1;
    model_find(bus.d_rs, bus.d_rs_used, hs, rs_, is);
    model_find(bus.d_rt, bus.d_rt_used, ht, rt_, it);
    st = bus.d_valid && ((hs && !rs_) || (ht && !rt_));
    lu = bus.d_valid && ((hs && !rs_ && pipe[is].load) || (ht && !rt_ && pipe[it].load));
    check_eq("stall", bus.stall, st);
    if (!st) begin
      check_eq("vs_fwd", bus.vs_fwd, (hs && rs_) ? slice(is) : cur_vs);
      check_eq("vt_fwd", bus.vt_fwd, (ht && rt_) ? slice(it) : cur_vt);
    end
    foreach (pipe[i]) sv[i] = pipe[i].valid;
    check_eq("stage_valid", bus.stage_valid, sv);
    @(posedge clk);
    if (!bus.freeze) begin
      e.valid = bus.d_valid && bus.d_wen && !st && !bus.flush;
      e.rd    = bus.d_rd;
      e.load  = bus.d_load;
      pipe.push_front(e);
      void'(pipe.pop_back());
`ifdef HAZARD_STATS_EN
      if (st) exp_stall_cnt++;
      if (lu) exp_lu_cnt++;
`endif
    end
    #1;
  endtask

  task automatic drain();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (NSTAGE) cycle();
  endtask

  initial begin
    resetn = 1'b0;
    bus.freeze = 0;
    bus.flush  = 0;
    bus.stage_data = {$urandom, $urandom, $urandom};
    instr(1, 3, 4, 1, 1, 5, 1, 0);
    model_clear();
    #12;
    check_eq("rst_stage_valid", bus.stage_valid, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_vs_fwd", bus.vs_fwd, cur_vs);
    check_eq("rst_vt_fwd", bus.vt_fwd, cur_vt);
    resetn = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // ALU RAW back-to-back: one stall, then forward from stage 1
    instr(1, 1, 2, 1, 1, 3, 1, 0); cycle();
    instr(1, 3, 1, 1, 1, 4, 1, 0);
    #1 check_eq("alu_raw_stall", bus.stall, 1);
    cycle();
    bus.stage_data[1*DW +: DW] = 32'h12345678;
    #1 check_eq("alu_raw_nostall", bus.stall, 0);
    check_eq("alu_raw_fwd", bus.vs_fwd, 32'h12345678);
    cycle();
    drain();

    // Load-use: two stalls, then both operands from stage 2
    instr(1, 1, 2, 1, 1, 5, 1, 1); cycle();
    instr(1, 5, 5, 1, 1, 6, 1, 0);
    #1 check_eq("lu_stall1", bus.stall, 1);
    cycle();
    #1 check_eq("lu_stall2", bus.stall, 1);
    cycle();
    bus.stage_data[2*DW +: DW] = 32'hDEADBEEF;
    #1 check_eq("lu_nostall", bus.stall, 0);
    check_eq("lu_vs", bus.vs_fwd, 32'hDEADBEEF);
    check_eq("lu_vt", bus.vt_fwd, 32'hDEADBEEF);
    cycle();
    drain();

    // Two writers of $7: the younger value must be forwarded
    instr(1, 0, 0, 0, 0, 7, 1, 0); cycle();
    instr(1, 0, 0, 0, 0, 7, 1, 0); cycle();
    instr(1, 7, 0, 1, 0, 8, 1, 0);
    #1 check_eq("young_stall", bus.stall, 1);
    cycle();
    bus.stage_data[1*DW +: DW] = 32'hBBBB0002;
    bus.stage_data[2*DW +: DW] = 32'hAAAA0001;
    #1 check_eq("young_fwd", bus.vs_fwd, 32'hBBBB0002);
    cycle();
    drain();

    // $0 never matches; an unused source never stalls
    instr(1, 0, 0, 0, 0, 0, 1, 0); cycle();
    instr(1, 0, 0, 1, 1, 9, 1, 0);
    #1 check_eq("zero_stall", bus.stall, 0);
    check_eq("zero_vs", bus.vs_fwd, cur_vs);
    cycle();
    instr(1, 1, 9, 1, 0, 2, 1, 0);
    #1 check_eq("unused_stall", bus.stall, 0);
    cycle();
    drain();

    // freeze holds every entry; flush squashes the decode writer
    instr(1, 0, 0, 0, 0, 11, 1, 0); cycle();
    instr(1, 0, 0, 0, 0, 12, 1, 0); cycle();
    instr(1, 0, 0, 0, 0, 13, 1, 1); cycle();
    bus.freeze = 1;
    instr(1, 0, 0, 0, 0, 14, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("freeze_hold", bus.stage_valid, 3'b111);
    end
    bus.freeze = 0;
    bus.flush  = 1;
    instr(1, 0, 0, 0, 0, 10, 1, 0); cycle();
    bus.flush  = 0;
    check_eq("flush_e_invalid", bus.stage_valid[0], 0);
    instr(1, 10, 0, 1, 0, 2, 1, 0);
    #1 check_eq("flush_no_stall", bus.stall, 0);
    cycle();
    drain();

    // Asynchronous reset between clock edges
    instr(1, 0, 0, 0, 0, 14, 1, 0); cycle();
    instr(1, 0, 0, 0, 0, 15, 1, 0); cycle();
    instr(1, 0, 0, 0, 0, 16, 1, 0); cycle();
    instr(1, 16, 0, 1, 0, 2, 1, 0);
    #1 check_eq("pre_rst_stall", bus.stall, 1);
    #1 resetn = 1'b0;
    #1 check_eq("async_rst_valid", bus.stage_valid, 0);
    check_eq("async_rst_stall", bus.stall, 0);
    check_eq("async_rst_vs", bus.vs_fwd, cur_vs);
    resetn = 1'b1;
    model_clear();
`ifdef HAZARD_STATS_EN
    exp_stall_cnt = 0;
    exp_lu_cnt    = 0;
`endif
    cycle();

    // Random traffic over a small register set to provoke frequent hazards
    for (int k = 0; k < 400; k++) begin
      instr($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 3) == 0);
      bus.freeze     = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.stage_data = {$urandom, $urandom, $urandom};
      cycle();
    end
    bus.freeze = 0;
    bus.flush  = 0;

`ifdef HAZARD_STATS_EN
    check_eq("stall_cnt", stall_cnt, exp_stall_cnt);
    check_eq("loaduse_cnt", loaduse_cnt, exp_lu_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
